// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: one instruction-fetch port and one data port share a single RAM.
// Data normally wins; a saturating streak counter caps how long a pending fetch can be starved.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        halt,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state_r;
  state_t     next_state_s;
  logic [3:0] streak_r;
  logic [3:0] next_streak_s;
  logic       i_elig_s;
  logic       d_req_s;
  logic       starve_s;

  assign i_elig_s = iREN & ~halt;
  assign d_req_s  = dREN | dWEN;
  assign starve_s = (streak_r >= STARVE_LIM);

  // Wait flags drop in the very cycle the RAM reports ACCESS for the granted side.
  assign iwait = iREN    & ~((state_r == IGRANT) & (ramstate == RAM_ACCESS));
  assign dwait = d_req_s & ~((state_r == DGRANT) & (ramstate == RAM_ACCESS));

  // Arbitration decision, RAM drive and completion bookkeeping.
  always_comb begin
    next_state_s  = state_r;
    next_streak_s = streak_r;
    ramREN        = 1'b0;
    ramWEN        = 1'b0;
    ramaddr       = 32'h0000_0000;
    ramstore      = 32'h0000_0000;
    iload         = 32'h0000_0000;
    dload         = 32'h0000_0000;
    err           = 1'b0;
    case (state_r)
      IDLE: begin
        if (d_req_s && !(i_elig_s && starve_s)) begin
          next_state_s = DGRANT;
        end else if (i_elig_s) begin
          next_state_s = IGRANT;
        end else begin
          next_state_s = IDLE;
        end
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        // A withdrawn fetch releases the RAM without completing or flagging an error.
        if (!iREN) begin
          next_state_s = IDLE;
        end else begin
          case (ramstate)
            RAM_ACCESS: begin
              next_state_s  = IDLE;
              next_streak_s = 4'd0;
            end
            RAM_ERROR: begin
              err          = 1'b1;
              next_state_s = IDLE;
            end
            default: next_state_s = IGRANT;
          endcase
        end
      end
      DGRANT: begin
        ramaddr = daddr;
        dload   = ramload;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = dREN;
        end
        if (!d_req_s) begin
          next_state_s = IDLE;
        end else begin
          case (ramstate)
            RAM_ACCESS: begin
              next_state_s = IDLE;
              // Only data grants that bypassed a waiting fetch count toward starvation.
              if (i_elig_s) begin
                next_streak_s = (streak_r == 4'hF) ? 4'hF : streak_r + 4'd1;
              end else begin
                next_streak_s = 4'd0;
              end
            end
            RAM_ERROR: begin
              err          = 1'b1;
              next_state_s = IDLE;
            end
            default: next_state_s = DGRANT;
          endcase
        end
      end
      default: begin
        next_state_s  = IDLE;
        next_streak_s = 4'd0;
      end
    endcase
  end

  // State and streak registers; reset abandons any grant in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r  <= IDLE;
      streak_r <= 4'd0;
    end else begin
      state_r  <= next_state_s;
      streak_r <= next_streak_s;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one task per scenario, inputs driven on the falling edge,
// outputs checked 1 ns later so both state and combinational outputs are settled.
module tb_mem_arbiter;

  localparam logic [1:0] RS_FREE   = 2'b00;
  localparam logic [1:0] RS_BUSY   = 2'b01;
  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, halt;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        ramREN, ramWEN, iwait, dwait, err;
  logic [31:0] ramaddr, ramstore, iload, dload;

  int vectors     = 0;
  int miscompares = 0;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .halt(halt), .ramload(ramload), .ramstate(ramstate),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic clear_inputs;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ramstate = RS_FREE;
  endtask

  task automatic do_reset;
    clear_inputs();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1; halt = 1'b0;
    iaddr = 32'h40; daddr = 32'h80; dstore = 32'h1234_5678;
    ramload = 32'hFFFF_FFFF; ramstate = RS_ACCESS;
    @(negedge CLK); #1;
    vectors++;
    if ({ramREN, ramWEN, err, iwait, dwait} !== 5'b00011) begin
      miscompares++;
      $display("FAIL reset_ctrl got ren/wen/err/iw/dw=%b expected 00011", {ramREN, ramWEN, err, iwait, dwait});
    end
    vectors++;
    if ((ramaddr | ramstore | iload | dload) !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data got addr=%h store=%h iload=%h dload=%h expected all 0", ramaddr, ramstore, iload, dload);
    end
    clear_inputs();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_single_fetch;
    do_reset();
    iREN = 1'b1; iaddr = 32'h40; ramload = 32'h2408_000A; ramstate = RS_BUSY; #1;
    vectors++;
    if (ramREN !== 1'b0 || iwait !== 1'b1) begin
      miscompares++;
      $display("FAIL fetch_idle got ramREN=%b iwait=%b expected 0 1", ramREN, iwait);
    end
    @(negedge CLK);
    for (int c = 0; c < 3; c++) begin
      ramstate = (c == 2) ? RS_ACCESS : RS_BUSY; #1;
      vectors++;
      if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin
        miscompares++;
        $display("FAIL fetch_grant c=%0d got ren=%b wen=%b addr=%h expected 1 0 00000040", c, ramREN, ramWEN, ramaddr);
      end
      vectors++;
      if (iwait !== (c != 2)) begin
        miscompares++;
        $display("FAIL fetch_iwait c=%0d got %b expected %b", c, iwait, (c != 2));
      end
      if (c == 2) begin
        vectors++;
        if (iload !== 32'h2408_000A) begin
          miscompares++;
          $display("FAIL fetch_iload got %h expected 2408000a", iload);
        end
      end
      @(negedge CLK);
    end
    halt = 1'b1; ramstate = RS_BUSY; #1;
    vectors++;
    if (ramREN !== 1'b0 || iload !== 32'h0) begin
      miscompares++;
      $display("FAIL fetch_back_idle got ramREN=%b iload=%h expected 0 0", ramREN, iload);
    end
    @(negedge CLK);
    clear_inputs();
  endtask

  task automatic test_contention;
    do_reset();
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h40; daddr = 32'h80;
    ramload = 32'h0000_0011; ramstate = RS_ACCESS; #1;
    vectors++;
    if (ramREN !== 1'b0) begin
      miscompares++;
      $display("FAIL cont_idle got ramREN=%b expected 0", ramREN);
    end
    @(negedge CLK); #1;
    vectors++;
    if ({ramREN, ramWEN, dwait, iwait} !== 4'b1001 || ramaddr !== 32'h80) begin
      miscompares++;
      $display("FAIL cont_dgrant got ren/wen/dw/iw=%b addr=%h expected 1001 00000080", {ramREN, ramWEN, dwait, iwait}, ramaddr);
    end
    vectors++;
    if (dload !== 32'h11 || iload !== 32'h0) begin
      miscompares++;
      $display("FAIL cont_dload got dload=%h iload=%h expected 00000011 0", dload, iload);
    end
    @(negedge CLK);
    dREN = 1'b0; #1;
    vectors++;
    if (ramREN !== 1'b0 || dload !== 32'h0) begin
      miscompares++;
      $display("FAIL cont_mid_idle got ramREN=%b dload=%h expected 0 0", ramREN, dload);
    end
    @(negedge CLK); #1;
    vectors++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b0 || iload !== 32'h11 || dload !== 32'h0) begin
      miscompares++;
      $display("FAIL cont_igrant got ren=%b addr=%h iw=%b iload=%h dload=%h expected 1 00000040 0 00000011 0",
               ramREN, ramaddr, iwait, iload, dload);
    end
    @(negedge CLK);
    clear_inputs();
  endtask

  task automatic test_starvation;
    logic fetch;
    do_reset();
    iREN = 1'b1; dWEN = 1'b1; dREN = 1'b1; iaddr = 32'h200; daddr = 32'h100;
    dstore = 32'hDEAD_BEEF; ramstate = RS_ACCESS;
    for (int t = 0; t < 10; t++) begin
      fetch = (t == 4) || (t == 9);
      #1;
      vectors++;
      if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
        miscompares++;
        $display("FAIL starve_idle t=%0d got ren=%b wen=%b expected 0 0", t, ramREN, ramWEN);
      end
      @(negedge CLK); #1;
      vectors++;
      if ({ramREN, ramWEN} !== (fetch ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL starve_kind t=%0d got ren/wen=%b expected %b", t, {ramREN, ramWEN}, (fetch ? 2'b10 : 2'b01));
      end
      vectors++;
      if (ramaddr !== (fetch ? 32'h200 : 32'h100) || ramstore !== (fetch ? 32'h0 : 32'hDEAD_BEEF)) begin
        miscompares++;
        $display("FAIL starve_bus t=%0d got addr=%h store=%h expected %h %h", t, ramaddr, ramstore,
                 (fetch ? 32'h200 : 32'h100), (fetch ? 32'h0 : 32'hDEAD_BEEF));
      end
      vectors++;
      if (iwait !== !fetch || dwait !== fetch) begin
        miscompares++;
        $display("FAIL starve_wait t=%0d got iw=%b dw=%b expected %b %b", t, iwait, dwait, !fetch, fetch);
      end
      @(negedge CLK);
    end
    clear_inputs();
  endtask

  task automatic test_error;
    do_reset();
    dREN = 1'b1; daddr = 32'h80; ramstate = RS_ERROR; #1;
    vectors++;
    if ({err, dwait, ramREN} !== 3'b010) begin
      miscompares++;
      $display("FAIL err_idle got err/dw/ren=%b expected 010", {err, dwait, ramREN});
    end
    @(negedge CLK); #1;
    vectors++;
    if ({err, dwait, ramREN} !== 3'b111 || ramaddr !== 32'h80) begin
      miscompares++;
      $display("FAIL err_pulse got err/dw/ren=%b addr=%h expected 111 00000080", {err, dwait, ramREN}, ramaddr);
    end
    @(negedge CLK); #1;
    vectors++;
    if ({err, dwait, ramREN} !== 3'b010) begin
      miscompares++;
      $display("FAIL err_after got err/dw/ren=%b expected 010", {err, dwait, ramREN});
    end
    @(negedge CLK);
    ramstate = RS_ACCESS; #1;
    vectors++;
    if ({err, dwait, ramREN} !== 3'b001 || ramaddr !== 32'h80) begin
      miscompares++;
      $display("FAIL err_retry got err/dw/ren=%b addr=%h expected 001 00000080", {err, dwait, ramREN}, ramaddr);
    end
    @(negedge CLK);
    clear_inputs();
  endtask

  task automatic test_withdraw;
    do_reset();
    dREN = 1'b1; daddr = 32'h44; ramload = 32'h55; ramstate = RS_BUSY;
    @(negedge CLK); #1;
    vectors++;
    if (ramREN !== 1'b1 || dwait !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_grant got ren=%b dw=%b expected 1 1", ramREN, dwait);
    end
    @(negedge CLK);
    dREN = 1'b0; ramstate = RS_ERROR; #1;
    vectors++;
    if (ramREN !== 1'b0 || err !== 1'b0 || dload !== 32'h55) begin
      miscompares++;
      $display("FAIL wd_drop got ren=%b err=%b dload=%h expected 0 0 00000055", ramREN, err, dload);
    end
    @(negedge CLK);
    dREN = 1'b1; ramstate = RS_ACCESS; #1;
    vectors++;
    if (ramREN !== 1'b0 || dload !== 32'h0 || dwait !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_idle got ren=%b dload=%h dw=%b expected 0 0 1", ramREN, dload, dwait);
    end
    @(negedge CLK);
    clear_inputs();
  endtask

  task automatic test_halt;
    do_reset();
    halt = 1'b1; iREN = 1'b1; iaddr = 32'h40; ramload = 32'h77; ramstate = RS_ACCESS;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (ramREN !== 1'b0 || iwait !== 1'b1) begin
        miscompares++;
        $display("FAIL halt_block c=%0d got ren=%b iw=%b expected 0 1", c, ramREN, iwait);
      end
      @(negedge CLK);
    end
    halt = 1'b0; #1;
    @(negedge CLK);
    halt = 1'b1; ramstate = RS_BUSY; #1;
    vectors++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_mid got ren=%b addr=%h iw=%b expected 1 00000040 1", ramREN, ramaddr, iwait);
    end
    @(negedge CLK);
    ramstate = RS_ACCESS; #1;
    vectors++;
    if (ramREN !== 1'b1 || iwait !== 1'b0 || iload !== 32'h77) begin
      miscompares++;
      $display("FAIL halt_complete got ren=%b iw=%b iload=%h expected 1 0 00000077", ramREN, iwait, iload);
    end
    @(negedge CLK);
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if (ramREN !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_after c=%0d got ren=%b expected 0", c, ramREN);
      end
      @(negedge CLK);
    end
    clear_inputs();
  endtask

  task automatic test_async_reset;
    logic fetch;
    do_reset();
    iREN = 1'b1; dWEN = 1'b1; iaddr = 32'h200; daddr = 32'h300;
    dstore = 32'hCAFE_0001; ramstate = RS_ACCESS;
    // Three completed writes leave the streak one short of forcing a fetch.
    for (int t = 0; t < 3; t++) begin
      @(negedge CLK);
      @(negedge CLK);
    end
    ramstate = RS_BUSY;
    @(negedge CLK); #1;
    vectors++;
    if (ramWEN !== 1'b1 || ramstore !== 32'hCAFE_0001) begin
      miscompares++;
      $display("FAIL ar_write got wen=%b store=%h expected 1 cafe0001", ramWEN, ramstore);
    end
    ramstate = RS_ERROR; #1;
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL ar_err_pre got err=%b expected 1", err);
    end
    RST = 1'b1; #1;
    vectors++;
    if ({ramWEN, ramREN, err} !== 3'b000 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
      miscompares++;
      $display("FAIL ar_async got wen/ren/err=%b addr=%h store=%h expected 000 0 0", {ramWEN, ramREN, err}, ramaddr, ramstore);
    end
    @(negedge CLK);
    RST = 1'b0; ramstate = RS_ACCESS;
    // A cleared streak allows four more writes before the fetch gets through.
    for (int t = 0; t < 5; t++) begin
      fetch = (t == 4);
      @(negedge CLK); #1;
      vectors++;
      if ({ramREN, ramWEN} !== (fetch ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL ar_streak t=%0d got ren/wen=%b expected %b", t, {ramREN, ramWEN}, (fetch ? 2'b10 : 2'b01));
      end
      @(negedge CLK);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    RST = 1'b1;
    test_reset();
    test_single_fetch();
    test_contention();
    test_starvation();
    test_error();
    test_withdraw();
    test_halt();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
